sec_fir_sequencer: RTL and testbench
====================================

// Module: sec_fir_sequencer
// PURPOSE
//  Control sequencer for the sequential (single-MAC) FIR filter. Accepts one input sample per
//  val_in strobe, shifts the delay line and steps the coefficient ROM and sample mux addresses
//  through all taps. Drives MAC clear/enable aligned to the ROM/MAC pipeline and pulses val_out
//  when dout holds the finished sum. Sits beside MULT_ACC/REG_MUX/ROM in the filter top.
// PARAMETERS
//  Num_coef  17  number of taps, >=2
//  ROM_LAT    1  cycles from addr to valid coef/sample at MAC input, >=1
//  MAC_LAT    1  cycles from last MAC enable to valid dout, >=1
//  AW  (localparam) clog2(Num_coef), address width
// PORTS
//  clk      in   1   single clock, rising edge
//  rst      in   1   asynchronous, active-low reset
//  val_in   in   1   input sample valid strobe
//  addr     out  AW  tap index to ROM and REG_MUX
//  ce_reg   out  1   delay-line shift enable
//  ce_acc   out  1   MAC accumulate enable
//  rst_acc  out  1   with ce_acc: load product instead of add (first tap)
//  busy     out  1   sample in flight; val_in ignored
//  val_out  out  1   one-cycle pulse, filter result valid
//  overrun  out  1   only with SEC_FIR_OVERRUN_EN, see CONFIGURATION
// BEHAVIOUR
//  - Reset (rst=0, async): state IDLE, addr=0, counters 0, pipe cleared, ce_acc=rst_acc=0,
//    val_out=0, busy=0, overrun=0. Mid-operation reset aborts the sample; no val_out follows.
//  - FSM: IDLE -> RUN -> DRAIN -> DONE -> IDLE.
//  - Accept = val_in & (state==IDLE | state==DONE). ce_reg = Accept (combinational, same cycle).
//    Accepting in DONE goes straight to RUN (back-to-back).
//  - RUN: addr = 0,1,...,Num_coef-1, one per cycle, starting cycle after Accept. After
//    addr=Num_coef-1 -> DRAIN. addr holds 0 outside RUN.
//  - ce_acc = issue-valid delayed ROM_LAT cycles; rst_acc = tap-0 flag delayed ROM_LAT. Exactly
//    Num_coef ce_acc cycles per sample, rst_acc high only on the first.
//  - DRAIN: ROM_LAT+MAC_LAT-1 cycles, then DONE. DONE lasts 1 cycle, val_out=1 only there.
//  - Latency Accept -> val_out = Num_coef+ROM_LAT+MAC_LAT cycles (19 for defaults).
//    Max rate one sample per that many cycles.
//  - busy = (state==RUN | state==DRAIN). val_in while busy: ignored, no ce_reg, no side effect.
//  - Counter wraps are not permitted; tap counter saturates at Num_coef-1 and is reloaded to 0.
// CONFIGURATION
//  SEC_FIR_OVERRUN_EN defined: port overrun present. Sticky, set the cycle after any val_in
//    seen while busy; cleared only by reset.
//  Not defined: no overrun port, no logic; dropped samples are silent.
// STRUCTURE
//  - Package sec_fir_pkg: state typedef (IDLE,RUN,DRAIN,DONE), clog2 function, default
//    ROM_LAT/MAC_LAT constants shared with the filter top.
//  - Sub-module sec_fir_valid_pipe: ROM_LAT-deep shift register carrying {valid, first},
//    producing ce_acc/rst_acc. The FSM and tap counter stay in sec_fir_sequencer.
// TESTING
//  1. Defaults, val_in pulse at cycle 0 -> ce_reg@0; addr 0..16 @1..17; ce_acc @2..18;
//     rst_acc @2 only; val_out @19 only; busy @1..18.
//  2. val_in held high -> accepts @0,19,38; val_out @19,38,57; ce_reg only on those cycles.
//  3. Extra val_in @5 -> no ce_reg, sequence unchanged; with macro overrun=1 from @6 until
//     reset.
//  4. rst low @10 -> outputs 0 immediately, no val_out. After release, val_in gives clean 19-cycle
//     sequence.
//  5. Num_coef=2, ROM_LAT=2, MAC_LAT=1, val_in @0 -> addr 0,1 @1,2; ce_acc @3,4; val_out @5.
//  6. Random val_in 10k cycles vs reference model: ce_acc count = Num_coef per val_out,
//     rst_acc once per val_out.

Source files
------------

// File: rtl/sec_fir_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sec_fir_pkg
//  Description : Shared definitions for the sequential (single-MAC) FIR
//                filter: sequencer state encoding, a constant clog2 helper
//                and the default ROM/MAC pipeline latencies used by both the
//                sequencer and the filter top.
//  Revision    : 1.0 - initial release
// ============================================================================
package sec_fir_pkg;

    // Sequencer states. The sequencer mirrors these as localparam constants
    // so the encoding stays fixed for downstream tools reading the netlist.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } sec_fir_state_e;

    // Default pipeline latencies shared with the filter top.
    localparam int c_DEF_ROM_LAT = 1;
    localparam int c_DEF_MAC_LAT = 1;

    // Ceiling log2 with a floor of 1 bit, so a counter that only ever
    // needs the value 0 still gets a legal width.
    function automatic int sec_fir_clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage : sec_fir_pkg
`default_nettype wire

// File: rtl/sec_fir_valid_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : sec_fir_valid_pipe
//  Description : DEPTH-stage shift register carrying the {valid, first} tap
//                flags from the address issue point to the MAC input, so the
//                accumulate enable lines up with the coefficient and sample
//                read out of the ROM / register mux.
//  Ports       : clk        - clock, rising edge
//                rst        - asynchronous, active-low reset
//                valid_in   - a tap address is being issued this cycle
//                first_in   - the issued address is tap 0
//                valid_out  - valid_in delayed DEPTH cycles (MAC enable)
//                first_out  - first_in delayed DEPTH cycles (MAC load)
//  Revision    : 1.0 - initial release
// ============================================================================
module sec_fir_valid_pipe #(
    parameter int DEPTH = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic valid_in,
    input  logic first_in,
    output logic valid_out,
    output logic first_out
);

    logic [DEPTH-1:0] r_valid;
    logic [DEPTH-1:0] r_first;

    generate
        if (DEPTH == 1) begin : g_single
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_valid <= '0;
                    r_first <= '0;
                end else begin
                    r_valid <= valid_in;
                    r_first <= first_in;
                end
            end
        end else begin : g_multi
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_valid <= '0;
                    r_first <= '0;
                end else begin
                    r_valid <= {r_valid[DEPTH-2:0], valid_in};
                    r_first <= {r_first[DEPTH-2:0], first_in};
                end
            end
        end
    endgenerate

    assign valid_out = r_valid[DEPTH-1];
    assign first_out = r_first[DEPTH-1];

endmodule : sec_fir_valid_pipe
`default_nettype wire

// File: rtl/sec_fir_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : sec_fir_sequencer
//  Description : Control sequencer for the single-MAC FIR filter. Accepts one
//                sample per val_in strobe, shifts the delay line, walks the
//                tap address through 0..Num_coef-1, drives MAC clear/enable
//                aligned to the ROM pipeline and pulses val_out once dout
//                holds the finished sum.
//  Ports       : clk      - clock, rising edge
//                rst      - asynchronous, active-low reset
//                val_in   - input sample valid strobe
//                addr     - tap index to ROM and register mux
//                ce_reg   - delay-line shift enable (same cycle as accept)
//                ce_acc   - MAC accumulate enable
//                rst_acc  - with ce_acc, load product instead of add
//                busy     - sample in flight, val_in ignored
//                val_out  - one-cycle pulse, filter result valid
//                overrun  - sticky dropped-sample flag (optional)
//  Config      : SEC_FIR_OVERRUN_EN - when defined, adds the overrun port and
//                its sticky flag; otherwise dropped samples are silent.
//  Revision    : 1.0 - initial release
// ============================================================================
module sec_fir_sequencer
    import sec_fir_pkg::*;
#(
    parameter int Num_coef = 17,
    parameter int ROM_LAT  = c_DEF_ROM_LAT,
    parameter int MAC_LAT  = c_DEF_MAC_LAT,
    localparam int AW      = sec_fir_clog2(Num_coef)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          val_in,
    output logic [AW-1:0] addr,
    output logic          ce_reg,
    output logic          ce_acc,
    output logic          rst_acc,
    output logic          busy,
    output logic          val_out
`ifdef SEC_FIR_OVERRUN_EN
    ,
    output logic          overrun
`endif
);

    localparam logic [1:0] c_ST_IDLE  = ST_IDLE;
    localparam logic [1:0] c_ST_RUN   = ST_RUN;
    localparam logic [1:0] c_ST_DRAIN = ST_DRAIN;
    localparam logic [1:0] c_ST_DONE  = ST_DONE;

    // After the last address issue, the final product needs ROM_LAT cycles
    // to reach the MAC and MAC_LAT more to land in dout; DONE itself covers
    // the last of those cycles, so DRAIN is one shorter.
    localparam int              c_DRAIN_LEN  = ROM_LAT + MAC_LAT - 1;
    localparam int              c_DW         = sec_fir_clog2(c_DRAIN_LEN);
    localparam logic [AW-1:0]   c_LAST_TAP   = AW'(Num_coef - 1);
    localparam logic [c_DW-1:0] c_DRAIN_LAST = c_DW'(c_DRAIN_LEN - 1);

    logic [1:0]      r_state;
    logic [AW-1:0]   r_tap;
    logic [c_DW-1:0] r_drain;

    logic w_accept;
    logic w_busy;
    logic w_issue;
    logic w_first;

    // A sample is taken only when the previous one is finished (IDLE) or is
    // presenting its result this cycle (DONE), which allows back-to-back
    // operation without a bubble.
    assign w_accept = val_in & ((r_state == c_ST_IDLE) | (r_state == c_ST_DONE));
    assign w_busy   = (r_state == c_ST_RUN) | (r_state == c_ST_DRAIN);
    assign w_issue  = (r_state == c_ST_RUN);
    assign w_first  = w_issue & (r_tap == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= c_ST_IDLE;
            r_tap   <= '0;
            r_drain <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_accept) begin
                        r_state <= c_ST_RUN;
                    end
                end
                c_ST_RUN: begin
                    // Tap counter never wraps: it stops at the last tap and
                    // is explicitly reloaded for the next sample.
                    if (r_tap == c_LAST_TAP) begin
                        r_tap   <= '0;
                        r_state <= c_ST_DRAIN;
                    end else begin
                        r_tap <= r_tap + AW'(1);
                    end
                end
                c_ST_DRAIN: begin
                    if (r_drain == c_DRAIN_LAST) begin
                        r_drain <= '0;
                        r_state <= c_ST_DONE;
                    end else begin
                        r_drain <= r_drain + c_DW'(1);
                    end
                end
                c_ST_DONE: begin
                    r_state <= w_accept ? c_ST_RUN : c_ST_IDLE;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                    r_tap   <= '0;
                    r_drain <= '0;
                end
            endcase
        end
    end

    sec_fir_valid_pipe #(
        .DEPTH     (ROM_LAT)
    ) u_valid_pipe (
        .clk       (clk),
        .rst       (rst),
        .valid_in  (w_issue),
        .first_in  (w_first),
        .valid_out (ce_acc),
        .first_out (rst_acc)
    );

    assign addr    = w_issue ? r_tap : '0;
    assign ce_reg  = w_accept;
    assign busy    = w_busy;
    assign val_out = (r_state == c_ST_DONE);

`ifdef SEC_FIR_OVERRUN_EN
    logic r_overrun;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_overrun <= 1'b0;
        end else if (val_in & w_busy) begin
            r_overrun <= 1'b1;
        end
    end

    assign overrun = r_overrun;
`endif

endmodule : sec_fir_sequencer
`default_nettype wire

// File: tb/tb_sec_fir_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sec_fir_sequencer
//  Description : Self-checking bench for sec_fir_sequencer. Two instances
//                (default 17/1/1 and a 2/2/1 variant) share val_in and rst.
//                The model works from sample accept times: every output is
//                a function of the distance from the latest accept.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sec_fir_sequencer;

    logic clk;
    logic rst;
    logic val_in;

    logic [4:0] addr0;
    logic       ce_reg0, ce_acc0, rst_acc0, busy0, val_out0, ov0;
    logic [0:0] addr1;
    logic       ce_reg1, ce_acc1, rst_acc1, busy1, val_out1, ov1;

    sec_fir_sequencer #(
        .Num_coef (17),
        .ROM_LAT  (1),
        .MAC_LAT  (1)
    ) u_dut0 (
        .clk     (clk),
        .rst     (rst),
        .val_in  (val_in),
        .addr    (addr0),
        .ce_reg  (ce_reg0),
        .ce_acc  (ce_acc0),
        .rst_acc (rst_acc0),
        .busy    (busy0),
        .val_out (val_out0)
`ifdef SEC_FIR_OVERRUN_EN
        ,
        .overrun (ov0)
`endif
    );

    sec_fir_sequencer #(
        .Num_coef (2),
        .ROM_LAT  (2),
        .MAC_LAT  (1)
    ) u_dut1 (
        .clk     (clk),
        .rst     (rst),
        .val_in  (val_in),
        .addr    (addr1),
        .ce_reg  (ce_reg1),
        .ce_acc  (ce_acc1),
        .rst_acc (rst_acc1),
        .busy    (busy1),
        .val_out (val_out1)
`ifdef SEC_FIR_OVERRUN_EN
        ,
        .overrun (ov1)
`endif
    );

`ifndef SEC_FIR_OVERRUN_EN
    assign ov0 = 1'b0;
    assign ov1 = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instance configuration: taps, ROM latency, MAC latency.
    int nn [2];
    int rr [2];
    int mm [2];

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = -1;

    // Model state
    int la     [2];
    bit has_la [2];
    bit ov_st  [2];

    // Expected per-cycle outputs, written at posedge+1, checked at negedge
    int e_addr    [2];
    bit e_ce_reg  [2];
    bit e_ce_acc  [2];
    bit e_rst_acc [2];
    bit e_busy    [2];
    bit e_ov      [2];

    // Scoreboard: expected val_out cycles per instance
    int q0 [$];
    int q1 [$];

    function automatic int q_size(input int i);
        return (i == 0) ? q0.size() : q1.size();
    endfunction

    function automatic int q_front(input int i);
        return (i == 0) ? q0[0] : q1[0];
    endfunction

    function automatic void q_pop(input int i);
        if (i == 0) void'(q0.pop_front());
        else        void'(q1.pop_front());
    endfunction

    function automatic void q_push(input int i, input int v);
        if (i == 0) q0.push_back(v);
        else        q1.push_back(v);
    endfunction

    function automatic void q_clear(input int i);
        if (i == 0) q0.delete();
        else        q1.delete();
    endfunction

    function automatic void chk(input string name, input int i, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            if (n_errors <= 40)
                $display("FAIL %s inst=%0d cyc=%0d got=%0d expected=%0d", name, i, cyc, act, exp);
        end
    endfunction

    // One clock cycle of stimulus: drive, then compute what both instances
    // must show during this cycle from the accept history so far.
    task automatic step(input bit v, input bit in_reset);
        @(posedge clk);
        #1;
        cyc++;
        rst    = in_reset ? 1'b0 : 1'b1;
        val_in = in_reset ? 1'b0 : v;
        for (int i = 0; i < 2; i++) begin
            int lat;
            int d;
            bit acc;
            lat = nn[i] + rr[i] + mm[i];
            if (in_reset) begin
                has_la[i]    = 1'b0;
                ov_st[i]     = 1'b0;
                q_clear(i);
                e_addr[i]    = 0;
                e_ce_reg[i]  = 1'b0;
                e_ce_acc[i]  = 1'b0;
                e_rst_acc[i] = 1'b0;
                e_busy[i]    = 1'b0;
                e_ov[i]      = 1'b0;
            end else begin
                d = has_la[i] ? (cyc - la[i]) : -1;
                e_busy[i]    = (d >= 1) && (d <= lat - 1);
                e_addr[i]    = ((d >= 1) && (d <= nn[i])) ? d - 1 : 0;
                e_ce_acc[i]  = (d >= 1 + rr[i]) && (d <= nn[i] + rr[i]);
                e_rst_acc[i] = (d == 1 + rr[i]);
                e_ov[i]      = ov_st[i];
                acc          = v && ((d < 0) || (d >= lat));
                e_ce_reg[i]  = acc;
                if (v && e_busy[i]) ov_st[i] = 1'b1;
                if (acc) begin
                    la[i]     = cyc;
                    has_la[i] = 1'b1;
                    q_push(i, cyc + lat);
                end
            end
        end
    endtask

    // Monitor: compares level outputs every cycle and pops the scoreboard
    // whenever an instance presents val_out.
    int cnt_acc   [2];
    int cnt_first [2];

    always @(negedge clk) begin
        if (cyc >= 0) begin
            for (int i = 0; i < 2; i++) begin
                int a_addr;
                bit a_ce_reg, a_ce_acc, a_rst_acc, a_busy, a_vo, a_ov;
                a_addr    = (i == 0) ? int'(addr0) : int'(addr1);
                a_ce_reg  = (i == 0) ? ce_reg0  : ce_reg1;
                a_ce_acc  = (i == 0) ? ce_acc0  : ce_acc1;
                a_rst_acc = (i == 0) ? rst_acc0 : rst_acc1;
                a_busy    = (i == 0) ? busy0    : busy1;
                a_vo      = (i == 0) ? val_out0 : val_out1;
                a_ov      = (i == 0) ? ov0      : ov1;

                chk("addr",    i, a_addr,          e_addr[i]);
                chk("ce_reg",  i, int'(a_ce_reg),  int'(e_ce_reg[i]));
                chk("ce_acc",  i, int'(a_ce_acc),  int'(e_ce_acc[i]));
                chk("rst_acc", i, int'(a_rst_acc), int'(e_rst_acc[i]));
                chk("busy",    i, int'(a_busy),    int'(e_busy[i]));
`ifdef SEC_FIR_OVERRUN_EN
                chk("overrun", i, int'(a_ov),      int'(e_ov[i]));
`else
                if (a_ov) chk("overrun_absent", i, 1, 0);
`endif

                if (!rst) begin
                    cnt_acc[i]   = 0;
                    cnt_first[i] = 0;
                end
                if (a_ce_acc)  cnt_acc[i]++;
                if (a_rst_acc) cnt_first[i]++;

                if ((q_size(i) > 0) && (q_front(i) < cyc)) begin
                    chk("val_out_missing", i, 0, 1);
                    q_pop(i);
                end
                if (a_vo) begin
                    if (q_size(i) == 0) begin
                        chk("val_out_unexpected", i, 1, 0);
                    end else begin
                        chk("val_out_cycle", i, cyc, q_front(i));
                        q_pop(i);
                        chk("ce_acc_count",  i, cnt_acc[i],   nn[i]);
                        chk("rst_acc_count", i, cnt_first[i], 1);
                    end
                    cnt_acc[i]   = 0;
                    cnt_first[i] = 0;
                end
            end
        end
    end

    initial begin
        nn[0] = 17; rr[0] = 1; mm[0] = 1;
        nn[1] = 2;  rr[1] = 2; mm[1] = 1;
        for (int i = 0; i < 2; i++) begin
            has_la[i] = 1'b0; ov_st[i] = 1'b0; la[i] = 0;
            e_addr[i] = 0; e_ce_reg[i] = 0; e_ce_acc[i] = 0;
            e_rst_acc[i] = 0; e_busy[i] = 0; e_ov[i] = 0;
            cnt_acc[i] = 0; cnt_first[i] = 0;
        end
        rst    = 1'b0;
        val_in = 1'b0;

        // Reset state
        for (int k = 0; k < 3; k++) step(1'b0, 1'b1);

        // Single sample
        step(1'b1, 1'b0);
        for (int k = 0; k < 25; k++) step(1'b0, 1'b0);

        // val_in held high: back-to-back accepts
        for (int k = 0; k < 60; k++) step(1'b1, 1'b0);
        for (int k = 0; k < 25; k++) step(1'b0, 1'b0);

        // Extra strobe while busy
        step(1'b1, 1'b0);
        for (int k = 0; k < 4; k++) step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        for (int k = 0; k < 25; k++) step(1'b0, 1'b0);

        // Reset mid-sample, then a clean sample
        step(1'b1, 1'b0);
        for (int k = 0; k < 9; k++) step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        for (int k = 0; k < 3; k++) step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        for (int k = 0; k < 25; k++) step(1'b0, 1'b0);

        // Random traffic with rare resets
        for (int k = 0; k < 10000; k++) begin
            if ($urandom_range(0, 1499) == 0)
                step(1'b0, 1'b1);
            else
                step($urandom_range(0, 99) < 15, 1'b0);
        end
        for (int k = 0; k < 40; k++) step(1'b0, 1'b0);

        @(negedge clk);
        #1;
        chk("scoreboard_empty", 0, q_size(0), 0);
        chk("scoreboard_empty", 1, q_size(1), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_sec_fir_sequencer
`default_nettype wire
